w_sched_ctrl: RTL and testbench

- Sequencer for the SHA-256 message-schedule datapath, one 512-bit block at a time.
- Accepts a block over a valid/ready handshake and latches it for the datapath.
- Drives the datapath's enable, word index and index-complete controls through all 64 W words.
- Waits for the schedule-complete flag, then starts the compression core and waits for its done. Also tracks block count and last-block status per message.

---
 rtl/w_sched_ctrl.sv | 129 ++++++++++++
 tb/tb_w_sched_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sched_ctrl.sv
`timescale 1ns/1ps
// w_sched_ctrl: sequences one 512-bit block through the SHA-256 message schedule and compression core.
// Optional watchdog (sched_err) is built only when WSCHED_TIMEOUT_EN is defined.
module w_sched_ctrl #(
  parameter int W_LENGTH       = 64,
  parameter int MSG_WIDTH      = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  input  logic [MSG_WIDTH-1:0]        blk_data,
  input  logic                        blk_last,
  output logic [MSG_WIDTH-1:0]        msg_vector,
  output logic                        w_enable,
  output logic [$clog2(W_LENGTH):0]   w_index,
  output logic                        w_index_complete,
  input  logic                        w_vector_complete,
  output logic                        comp_start,
  input  logic                        comp_done,
  output logic                        msg_done,
  output logic [7:0]                  block_count,
  output logic                        busy,
  output logic                        sched_err,
  output logic [1:0]                  dbg_state
);

  localparam int IW = $clog2(W_LENGTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W_LENGTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCHED = 2'd1, DRAIN = 2'd2, COMP = 2'd3} state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   accept;
  logic   done_ok;
  logic   to_hit;
  logic   to_fire;

  // Handshake: a block transfers on a rising edge where blk_valid && blk_ready; blk_ready is high
  // exactly in IDLE, and the source holds blk_data/blk_last stable until the transfer happens.
  assign accept  = blk_valid && (state_q == IDLE);
  // comp_done in the comp_start cycle belongs to no block yet.
  assign done_ok = comp_done && !comp_start;
  assign to_fire = to_hit && (((state_q == DRAIN) && !w_vector_complete) ||
                              ((state_q == COMP) && !done_ok));

`ifdef WSCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;

  assign to_hit = (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      sched_err <= 1'b0;
    end else begin
      if (((state_d == DRAIN) || (state_d == COMP)) && (state_d != state_q))
        wd_q <= '0;
      else if ((state_q == DRAIN) || (state_q == COMP))
        wd_q <= wd_q + WDW'(1);
      if (to_fire)
        sched_err <= 1'b1;
    end
  end
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES > 0);
  assign to_hit    = 1'b0;
  assign sched_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (blk_valid) state_d = SCHED;
      SCHED:   if (w_index == LAST_IDX) state_d = DRAIN;
      DRAIN: begin
        if (w_vector_complete) state_d = COMP;
        else if (to_fire)      state_d = IDLE;
      end
      COMP:    if (done_ok || to_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_ready        = (state_q == IDLE);
    busy             = (state_q != IDLE);
    w_enable         = (state_q != IDLE);
    w_index_complete = (state_q == DRAIN) || (state_q == COMP);
    dbg_state        = state_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_vector  <= '0;
      last_q      <= 1'b0;
      w_index     <= '0;
      comp_start  <= 1'b0;
      msg_done    <= 1'b0;
      block_count <= '0;
    end else begin
      comp_start <= (state_q == DRAIN) && w_vector_complete;
      msg_done   <= (state_q == COMP) && done_ok && last_q;
      if (accept) begin
        msg_vector <= blk_data;
        last_q     <= blk_last;
      end
      if ((state_q == IDLE) || (state_d == IDLE))
        w_index <= '0;
      else if ((state_q == SCHED) && (w_index != LAST_IDX))
        w_index <= w_index + IW'(1);
      // The count is visible for the msg_done cycle, then restarts for the next message.
      if (msg_done || to_fire)
        block_count <= '0;
      else if ((state_q == COMP) && done_ok && (block_count != 8'hFF))
        block_count <= block_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_w_sched_ctrl.sv
`timescale 1ns/1ps
// Directed bench for w_sched_ctrl: a table of blocks applied back to back, plus hand-written
// sequences for mid-operation reset, early comp_done, watchdog/indefinite wait and count saturation.
module tb_w_sched_ctrl;
  localparam int WL = 64;
  localparam int MW = 512;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [MW-1:0] blk_data = '0;
  logic          blk_last = 1'b0;
  logic [MW-1:0] msg_vector;
  logic          w_enable;
  logic [6:0]    w_index;
  logic          w_index_complete;
  logic          w_vector_complete = 1'b0;
  logic          comp_start;
  logic          comp_done = 1'b0;
  logic          msg_done;
  logic [7:0]    block_count;
  logic          busy;
  logic          sched_err;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  w_sched_ctrl #(.W_LENGTH(WL), .MSG_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last), .msg_vector(msg_vector), .w_enable(w_enable),
    .w_index(w_index), .w_index_complete(w_index_complete),
    .w_vector_complete(w_vector_complete), .comp_start(comp_start), .comp_done(comp_done),
    .msg_done(msg_done), .block_count(block_count), .busy(busy), .sched_err(sched_err),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    int            vc_delay;
    int            cd_delay;
    logic [7:0]    exp_count;
    logic          exp_md;
  } vec_t;

  vec_t          vecs[4];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            model_count = 0;
  logic [MW-1:0] cur_data;
  logic [MW-1:0] junk;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, dbg_state, 0);
    check({tag, "_blk_ready"}, blk_ready, 1);
    check({tag, "_msg_vector"}, msg_vector, 0);
    check({tag, "_w_enable"}, w_enable, 0);
    check({tag, "_w_index"}, w_index, 0);
    check({tag, "_index_complete"}, w_index_complete, 0);
    check({tag, "_comp_start"}, comp_start, 0);
    check({tag, "_msg_done"}, msg_done, 0);
    check({tag, "_block_count"}, block_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sched_err"}, sched_err, 0);
  endtask

  // Called at a negedge; returns at the negedge of the first DRAIN cycle.
  task automatic accept_and_sched(input logic [MW-1:0] data, input logic last);
    int waited = 0;
    int bad = 0;
    while (!blk_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("ready_wait", waited < 200, 1);
    check("w_enable_low_before_accept", w_enable, 0);
    cur_data  = data;
    blk_valid = 1'b1;
    blk_data  = data;
    blk_last  = last;
    @(negedge clock);
    blk_valid = 1'b0;
    check("accept_state", dbg_state, 1);
    check("msg_vector_latched", msg_vector, data);
    check("count_at_accept", block_count, model_count);
    check("msg_done_single", msg_done, 0);
    for (int i = 0; i < WL; i++) begin
      if (w_index !== 7'(i) || !w_enable || w_index_complete || blk_ready) bad++;
      if (i == 20) begin
        blk_valid = 1'b1;
        blk_data  = junk;
      end
      if (i == 21) blk_valid = 1'b0;
      @(negedge clock);
    end
    check("w_index_sequence", bad, 0);
    check("index_complete", w_index_complete, 1);
    check("index_hold", w_index, WL - 1);
    check("drain_state", dbg_state, 2);
    check("drain_enable", w_enable, 1);
  endtask

  // Called at the first DRAIN negedge; returns at the negedge of the first IDLE cycle.
  task automatic finish_block(input int vc_delay, input int cd_delay,
                              input logic [7:0] exp_count, input logic exp_md);
    int pulses = 0;
    int bad = 0;
    for (int i = 0; i < vc_delay; i++) begin
      @(negedge clock);
      if (comp_start) pulses++;
    end
    w_vector_complete = 1'b1;
    @(negedge clock);
    w_vector_complete = 1'b0;
    check("comp_state", dbg_state, 3);
    if (comp_start) pulses++;
    blk_valid = 1'b1;
    blk_data  = junk;
    for (int i = 0; i < cd_delay; i++) begin
      @(negedge clock);
      blk_valid = 1'b0;
      if (comp_start) pulses++;
      if (dbg_state !== 2'd3 || !w_enable || !w_index_complete) bad++;
    end
    check("comp_hold", bad, 0);
    comp_done = 1'b1;
    @(negedge clock);
    comp_done = 1'b0;
    check("comp_start_pulses", pulses, 1);
    check("msg_done", msg_done, exp_md);
    check("block_count_done", block_count, exp_count);
    check("idle_ready", blk_ready, 1);
    check("idle_enable", w_enable, 0);
    check("idle_index", w_index, 0);
    check("idle_complete", w_index_complete, 0);
    check("idle_busy", busy, 0);
    check("msg_vector_held", msg_vector, cur_data);
    model_count = exp_md ? 0 : int'(exp_count);
  endtask

  initial begin
    int pulses;
    junk = {16{32'h5A5A_C3C3}};
    vecs[0] = '{{64{8'hA5}},          1'b1, 3, 10, 8'd1, 1'b1};
    vecs[1] = '{{16{32'h1111_2222}},  1'b0, 1,  2, 8'd1, 1'b0};
    vecs[2] = '{{16{32'h3333_4444}},  1'b0, 0,  1, 8'd2, 1'b0};
    vecs[3] = '{{16{32'hDEAD_BEEF}},  1'b1, 5,  3, 8'd3, 1'b1};

    #1 reset = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 4; v++) begin
      accept_and_sched(vecs[v].data, vecs[v].last);
      finish_block(vecs[v].vc_delay, vecs[v].cd_delay, vecs[v].exp_count, vecs[v].exp_md);
    end
    @(negedge clock);
    check("table_end_msg_done", msg_done, 0);
    check("table_end_count", block_count, 0);

    // Reset in the middle of the schedule run.
    accept_and_sched({16{32'h0BAD_F00D}}, 1'b0);
    finish_block(0, 1, 8'd1, 1'b0);
    blk_valid = 1'b1;
    blk_data  = {16{32'h7777_8888}};
    blk_last  = 1'b1;
    @(negedge clock);
    blk_valid = 1'b0;
    repeat (20) @(negedge clock);
    check("index_before_reset", w_index, 20);
    check("count_before_reset", block_count, 1);
    #1 reset = 1'b0;
    #1 check_reset_values("midop");
    @(negedge clock);
    reset = 1'b1;
    model_count = 0;
    @(negedge clock);
    accept_and_sched({16{32'h9999_AAAA}}, 1'b1);
    finish_block(1, 3, 8'd1, 1'b1);

    // comp_done already high when comp_start fires.
    accept_and_sched({16{32'hCAFE_0001}}, 1'b1);
    comp_done = 1'b1;
    @(negedge clock);
    check("drain_ignores_done", dbg_state, 2);
    w_vector_complete = 1'b1;
    @(negedge clock);
    w_vector_complete = 1'b0;
    check("held_comp_start", comp_start, 1);
    check("held_comp_state", dbg_state, 3);
    @(negedge clock);
    check("coincident_done_ignored", dbg_state, 3);
    check("held_comp_start_low", comp_start, 0);
    @(negedge clock);
    comp_done = 1'b0;
    check("held_done_state", dbg_state, 0);
    check("held_msg_done", msg_done, 1);
    check("held_count", block_count, 1);
    model_count = 0;
    @(negedge clock);

    // Missing w_vector_complete: watchdog abort, or indefinite wait without it.
    accept_and_sched({16{32'h1234_5678}}, 1'b0);
    finish_block(0, 1, 8'd1, 1'b0);
    accept_and_sched({16{32'h8765_4321}}, 1'b1);
`ifdef WSCHED_TIMEOUT_EN
    pulses = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clock);
      if (comp_start) pulses++;
      if (k == TO - 1) check("err_before_timeout", sched_err, 0);
    end
    check("timeout_err", sched_err, 1);
    check("timeout_state", dbg_state, 0);
    check("timeout_ready", blk_ready, 1);
    check("timeout_enable", w_enable, 0);
    check("timeout_complete", w_index_complete, 0);
    check("timeout_index", w_index, 0);
    check("timeout_msg_done", msg_done, 0);
    check("timeout_count", block_count, 0);
    check("timeout_no_comp_start", pulses, 0);
    repeat (5) @(negedge clock);
    check("err_sticky", sched_err, 1);
    #1 reset = 1'b0;
    #1 check("err_cleared_by_reset", sched_err, 0);
    @(negedge clock);
    reset = 1'b1;
    model_count = 0;
    @(negedge clock);
`else
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (comp_start) pulses++;
    end
    check("wait_state", dbg_state, 2);
    check("wait_complete", w_index_complete, 1);
    check("wait_no_err", sched_err, 0);
    check("wait_no_comp_start", pulses, 0);
    finish_block(0, 2, 8'd2, 1'b1);
`endif

    // Block count saturates at 255 over a long message.
    for (int i = 0; i < 256; i++) begin
      accept_and_sched({16{i}}, 1'b0);
      finish_block(0, 1, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 1'b0);
    end
    accept_and_sched({16{32'hFFFF_0000}}, 1'b1);
    finish_block(0, 1, 8'd255, 1'b1);
    @(negedge clock);
    check("sat_msg_done_low", msg_done, 0);
    check("sat_count_cleared", block_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
